// File: rtl/jr_target_resolver_if.sv
// Request/response bundle between ID/fetch and the jr/jalr target resolver.
// master = pipeline side (ID issues requests, fetch consumes targets),
// slave  = the resolver.
interface jr_target_resolver_if #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 3
) ();
  logic              req_valid;
  logic              req_ready;
  logic [REG_AW-1:0] req_rs;
  logic [DATA_W-1:0] rf_rdata;
  logic              tgt_valid;
  logic              tgt_ready;
  logic [DATA_W-1:0] tgt_addr;
  logic [NUM_SRC:0]  tgt_sel;

  modport master (
    output req_valid, req_rs, rf_rdata, tgt_ready,
    input  req_ready, tgt_valid, tgt_addr, tgt_sel
  );

  modport slave (
    input  req_valid, req_rs, rf_rdata, tgt_ready,
    output req_ready, tgt_valid, tgt_addr, tgt_sel
  );
endinterface

// File: rtl/jr_target_resolver.sv
// Register-indirect jump target resolver. Picks the youngest in-flight
// producer of rs (or the register file), waits while that producer's data
// is pending, and hands the target to fetch over a valid/ready handshake.
module jr_target_resolver #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 3,
  parameter int MAX_WAIT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  jr_target_resolver_if.slave       bus,
  input  logic [NUM_SRC-1:0]        stg_wen,
  input  logic [NUM_SRC*REG_AW-1:0] stg_waddr,
  input  logic [NUM_SRC*DATA_W-1:0] stg_wdata,
  input  logic [NUM_SRC-1:0]        stg_rdy,
  output logic                      stall,
  output logic                      timeout_err
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tgt_valid_q, tgt_valid_d;
  logic [DATA_W-1:0] tgt_addr_q, tgt_addr_d;
  logic [NUM_SRC:0]  tgt_sel_q, tgt_sel_d;
  logic              timeout_q, timeout_d;

  // Match network: hit per stage, then keep only the lowest-index (youngest)
  // hit via a running "some younger stage already hit" chain.
  logic [NUM_SRC-1:0] hit;
  logic [NUM_SRC-1:0] first;
  logic [NUM_SRC:0]   lower_hit;
  logic [DATA_W-1:0]  data_acc [NUM_SRC+1];

  assign lower_hit[0] = 1'b0;
  assign data_acc[0]  = '0;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_match
    assign hit[gi] = stg_wen[gi]
                  && (stg_waddr[gi*REG_AW +: REG_AW] == bus.req_rs)
                  && (bus.req_rs != '0);
    assign first[gi]         = hit[gi] & ~lower_hit[gi];
    assign lower_hit[gi+1]   = lower_hit[gi] | hit[gi];
    // AND-OR mux: at most one stage contributes since first is one-hot.
    assign data_acc[gi+1]    = data_acc[gi]
                             | (first[gi] ? stg_wdata[gi*DATA_W +: DATA_W] : '0);
  end

  logic              no_hit;
  logic              win_ready;
  logic [DATA_W-1:0] win_data;
  logic [NUM_SRC:0]  win_sel;

  // r0 never hits a stage, so it falls through to the regfile slot with data 0.
  assign no_hit    = ~lower_hit[NUM_SRC];
  assign win_ready = no_hit | (|(first & stg_rdy));
  assign win_sel   = {first, no_hit};
  assign win_data  = no_hit ? ((bus.req_rs == '0) ? '0 : bus.rf_rdata)
                            : data_acc[NUM_SRC];

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tgt_valid_d = tgt_valid_q;
    tgt_addr_d  = tgt_addr_q;
    tgt_sel_d   = tgt_sel_q;
    timeout_d   = timeout_q;
    if (flush) begin
      state_d     = S_IDLE;
      tgt_valid_d = 1'b0;
      cnt_d       = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            if (win_ready) begin
              state_d     = S_RESP;
              tgt_valid_d = 1'b1;
              tgt_addr_d  = win_data;
              tgt_sel_d   = win_sel;
            end else begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (win_ready) begin
            state_d     = S_RESP;
            tgt_valid_d = 1'b1;
            tgt_addr_d  = win_data;
            tgt_sel_d   = win_sel;
          end else begin
            if (cnt_q != MAX_CNT) begin
              cnt_d = cnt_q + 1'b1;
            end
            if (cnt_d == MAX_CNT) begin
              timeout_d = 1'b1;
            end
          end
        end
        S_RESP: begin
          if (bus.tgt_ready) begin
            state_d     = S_IDLE;
            tgt_valid_d = 1'b0;
            cnt_d       = '0;
          end
        end
        default: begin
          state_d     = S_IDLE;
          tgt_valid_d = 1'b0;
          cnt_d       = '0;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tgt_valid_q <= 1'b0;
      tgt_addr_q  <= '0;
      tgt_sel_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tgt_valid_q <= tgt_valid_d;
      tgt_addr_q  <= tgt_addr_d;
      tgt_sel_q   <= tgt_sel_d;
      timeout_q   <= timeout_d;
    end
  end

  // ID freezes in the same cycle a pending producer is detected.
  assign stall = (state_q != S_IDLE)
              || (bus.req_valid && !win_ready);

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.tgt_valid = tgt_valid_q;
  assign bus.tgt_addr  = tgt_addr_q;
  assign bus.tgt_sel   = tgt_sel_q;
  assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_jr_target_resolver.sv
// Directed bench for jr_target_resolver: a transaction-level model checked
// every cycle, plus literal expectations for each directed scenario.
module tb_jr_target_resolver;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_SRC  = 3;
  localparam int MAX_WAIT = 4;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush;
  logic [NUM_SRC-1:0]        stg_wen;
  logic [NUM_SRC*REG_AW-1:0] stg_waddr;
  logic [NUM_SRC*DATA_W-1:0] stg_wdata;
  logic [NUM_SRC-1:0]        stg_rdy;
  logic                      stall;
  logic                      timeout_err;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  jr_target_resolver_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC)) bus ();

  jr_target_resolver #(
    .DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_SRC(NUM_SRC), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus),
    .stg_wen(stg_wen), .stg_waddr(stg_waddr), .stg_wdata(stg_wdata),
    .stg_rdy(stg_rdy), .stall(stall), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Spec-level source selection: youngest stage writing rs wins, r0 is 0.
  function automatic void resolve(output bit ok, output logic [31:0] d, output logic [3:0] sel);
    int win = -1;
    for (int i = 0; i < NUM_SRC; i++)
      if (win < 0 && stg_wen[i] && stg_waddr[i*REG_AW +: REG_AW] == bus.req_rs && bus.req_rs != 0)
        win = i;
    if (bus.req_rs == 0) begin
      ok = 1; d = 0; sel = 4'b0001;
    end else if (win < 0) begin
      ok = 1; d = bus.rf_rdata; sel = 4'b0001;
    end else begin
      ok = stg_rdy[win]; d = stg_wdata[win*DATA_W +: DATA_W]; sel = 4'(1 << (win + 1));
    end
  endfunction

  // Model: is a request waiting, is a target being offered, and what it holds.
  bit          m_waiting, m_offer, m_timeout;
  int          m_waits;
  logic [31:0] m_addr;
  logic [3:0]  m_sel;

  always @(posedge clk) begin
    bit ok; logic [31:0] d; logic [3:0] s;
    resolve(ok, d, s);
    if (rst) begin
      m_waiting = 0; m_offer = 0; m_timeout = 0; m_waits = 0; m_addr = 0; m_sel = 0;
    end else if (flush) begin
      m_waiting = 0; m_offer = 0; m_waits = 0;
    end else if (m_offer) begin
      if (bus.tgt_ready) begin m_offer = 0; m_waits = 0; end
    end else if (m_waiting || bus.req_valid) begin
      if (ok) begin
        m_waiting = 0; m_offer = 1; m_addr = d; m_sel = s;
      end else if (!m_waiting) begin
        m_waiting = 1;
      end else begin
        m_waits = (m_waits < MAX_WAIT) ? m_waits + 1 : MAX_WAIT;
        if (m_waits >= MAX_WAIT) m_timeout = 1;
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    bit ok; logic [31:0] d; logic [3:0] s;
    if (chk_en) begin
      resolve(ok, d, s);
      check("m_tgt_valid", 32'(bus.tgt_valid), 32'(m_offer));
      check("m_tgt_addr", bus.tgt_addr, m_addr);
      check("m_tgt_sel", 32'(bus.tgt_sel), 32'(m_sel));
      check("m_req_ready", 32'(bus.req_ready), 32'(!m_waiting && !m_offer));
      check("m_stall", 32'(stall), 32'(m_waiting || m_offer || (bus.req_valid && !ok)));
      check("m_timeout", 32'(timeout_err), 32'(m_timeout));
      if (bus.tgt_valid && bus.tgt_ready && !flush && !rst)
        $display("txn: tgt_addr=0x%08h tgt_sel=%b @%0t", bus.tgt_addr, bus.tgt_sel, $time);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stg();
    stg_wen = '0; stg_waddr = '0; stg_wdata = '0; stg_rdy = '1;
  endtask

  initial begin
    rst = 1; flush = 0; clear_stg();
    bus.req_valid = 0; bus.req_rs = 0; bus.rf_rdata = 0; bus.tgt_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    @(negedge clk);
    check("rst_valid", 32'(bus.tgt_valid), 0);
    check("rst_addr", bus.tgt_addr, 0);
    check("rst_sel", 32'(bus.tgt_sel), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_timeout", 32'(timeout_err), 0);
    cyc(); rst = 0;
    cyc();

    // 1: no hazard
    bus.req_valid = 1; bus.req_rs = 5; bus.rf_rdata = 32'h0040_0010;
    @(negedge clk);
    check("t1_stall", 32'(stall), 0);
    check("t1_req_ready", 32'(bus.req_ready), 1);
    cyc(); bus.req_valid = 0;
    @(negedge clk);
    check("t1_valid", 32'(bus.tgt_valid), 1);
    check("t1_addr", bus.tgt_addr, 32'h0040_0010);
    check("t1_sel", 32'(bus.tgt_sel), 32'b0001);
    cyc();

    // 2: stage 0 beats stage 2 on the same register
    bus.req_valid = 1; bus.req_rs = 8;
    stg_wen = 3'b101;
    stg_waddr = {5'd8, 5'd3, 5'd8};
    stg_wdata = {32'hC0, 32'hB0, 32'hA0};
    stg_rdy = 3'b111;
    cyc(); bus.req_valid = 0;
    @(negedge clk);
    check("t2_addr", bus.tgt_addr, 32'hA0);
    check("t2_sel", 32'(bus.tgt_sel), 32'b0010);
    cyc(); clear_stg();

    // 3: load-use, stage 0 pending for two cycles
    bus.req_valid = 1; bus.req_rs = 9;
    stg_wen = 3'b001; stg_waddr = {5'd0, 5'd0, 5'd9}; stg_wdata = {64'h0, 32'hDEAD};
    stg_rdy = 3'b110;
    @(negedge clk); check("t3_stall_c1", 32'(stall), 1);
    cyc();
    @(negedge clk); check("t3_stall_c2", 32'(stall), 1);
    cyc(); stg_rdy = 3'b111; stg_wdata = {64'h0, 32'h1234};
    @(negedge clk);
    check("t3_stall_c3", 32'(stall), 1);
    check("t3_valid_c3", 32'(bus.tgt_valid), 0);
    cyc(); bus.req_valid = 0;
    @(negedge clk);
    check("t3_valid_c4", 32'(bus.tgt_valid), 1);
    check("t3_addr", bus.tgt_addr, 32'h1234);
    cyc(); clear_stg();

    // 4: backpressure from fetch
    bus.req_valid = 1; bus.req_rs = 5; bus.rf_rdata = 32'h0000_1000; bus.tgt_ready = 0;
    cyc(); bus.req_valid = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t4_hold_valid", 32'(bus.tgt_valid), 1);
      check("t4_hold_addr", bus.tgt_addr, 32'h0000_1000);
      check("t4_hold_stall", 32'(stall), 1);
      cyc();
    end
    bus.tgt_ready = 1;
    @(negedge clk); check("t4_last_valid", 32'(bus.tgt_valid), 1);
    cyc();
    @(negedge clk);
    check("t4_idle", 32'(bus.req_ready), 1);
    check("t4_valid_drop", 32'(bus.tgt_valid), 0);
    cyc();

    // 5a: flush while waiting
    bus.req_valid = 1; bus.req_rs = 9;
    stg_wen = 3'b001; stg_waddr = {5'd0, 5'd0, 5'd9}; stg_rdy = 3'b110;
    cyc(); flush = 1; bus.req_valid = 0;
    @(negedge clk); check("t5_wait_stall", 32'(stall), 1);
    cyc(); flush = 0; clear_stg();
    @(negedge clk);
    check("t5_flush_idle", 32'(bus.req_ready), 1);
    check("t5_flush_novalid", 32'(bus.tgt_valid), 0);
    check("t5_flush_stall", 32'(stall), 0);
    cyc();

    // 5b: r0 ignores a stage writing r0
    bus.req_valid = 1; bus.req_rs = 0; bus.rf_rdata = 32'h5555_5555;
    stg_wen = 3'b001; stg_waddr = '0; stg_wdata = {64'h0, 32'hFF}; stg_rdy = 3'b111;
    cyc(); bus.req_valid = 0;
    @(negedge clk);
    check("t5_r0_addr", bus.tgt_addr, 0);
    check("t5_r0_sel", 32'(bus.tgt_sel), 32'b0001);
    cyc(); clear_stg();

    // 6: timeout after MAX_WAIT waiting cycles
    bus.req_valid = 1; bus.req_rs = 9;
    stg_wen = 3'b001; stg_waddr = {5'd0, 5'd0, 5'd9}; stg_wdata = {64'h0, 32'h77}; stg_rdy = 3'b110;
    cyc();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); check("t6_no_timeout", 32'(timeout_err), 0);
      cyc();
    end
    @(negedge clk); check("t6_timeout", 32'(timeout_err), 1);
    cyc(); stg_rdy = 3'b111;
    cyc(); bus.req_valid = 0;
    @(negedge clk);
    check("t6_resp_addr", bus.tgt_addr, 32'h77);
    check("t6_sticky", 32'(timeout_err), 1);
    cyc(); clear_stg();
    @(negedge clk); check("t6_sticky_idle", 32'(timeout_err), 1);
    cyc(); rst = 1;
    cyc(); rst = 0;
    @(negedge clk); check("t6_rst_clear", 32'(timeout_err), 0);
    cyc();

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
